seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 8, number of multiplexed seven-segment digits (2..8).
REQ-002 Parameter TICK_DIV, default 250000, clk cycles per digit slot.
REQ-003 Parameter BLANK_CYC, default 16, blanked cycles at start of each slot; legal range 1 <= BLANK_CYC < TICK_DIV.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 load_valid  input  1  host offers new display contents.
REQ-007 load_ready  output  1  block can accept new contents.
REQ-008 load_data  input  4*NUM_DIG  hex nibble per digit; digit 0 in bits [3:0].
REQ-009 load_dp  input  NUM_DIG  decimal-point enable per digit; captured with load_data.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 dig_sel  output  NUM_DIG  digit enables, active-low, at most one low.
REQ-013 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-014 Slot counter SHALL count 0..TICK_DIV-1 and wrap; slot end = count TICK_DIV-1.
REQ-015 FSM states BLANK and SHOW; BLANK while count < BLANK_CYC, SHOW otherwise; BLANK->SHOW at count BLANK_CYC, SHOW->BLANK at slot end.
REQ-016 In BLANK, dig_sel SHALL be all ones and seg 7'h7F, dp 1.
REQ-017 In SHOW, dig_sel bit [idx] low only; seg = hex decode of active nibble idx; dp = ~active_dp[idx].
REQ-018 All outputs registered and updated on the same edge as the state, so dig_sel is low exactly TICK_DIV-BLANK_CYC cycles per slot.
REQ-019 At slot end idx increments; NUM_DIG-1 wraps to 0.
REQ-020 frame_done SHALL pulse high for the single cycle following the slot end where idx wraps.
REQ-021 Hex decode: 0-9 and A,b,C,d,E,F standard glyphs, active-low.
REQ-022 load_ready = ~pending; transfer occurs when load_valid && load_ready; load_data/load_dp captured into shadow, pending set.
REQ-023 At wrap slot end with pending=1, active <= shadow, pending cleared; load_ready high next cycle.
REQ-024 Transfer in the same cycle as a wrap slot end SHALL be applied at the following wrap, not the current one.
REQ-025 load_valid while load_ready low SHALL be ignored; shadow unchanged.

Reset
REQ-026 While rst low: seg 7'h7F, dp 1, dig_sel all ones, frame_done 0, load_ready 1, active/shadow/pending 0, idx 0, counter 0, state BLANK.
REQ-027 Reset asserted mid-frame or mid-handshake SHALL discard pending update; first slot after release starts at counter 0, idx 0.

Configuration
REQ-028 Macro SEG_LZ_SUPPRESS_EN defined: in SHOW, digit idx > 0 whose nibble and all higher nibbles are zero and whose dp bit is 0 SHALL be blanked (dig_sel all ones); digit 0 always shown.
REQ-029 Macro undefined: every digit shown including leading zeros.

Structure
REQ-030 Package seg_pkg SHALL hold the 16-entry hex-to-segment table, SEG_OFF constant 7'h7F and the BLANK/SHOW state type.
REQ-031 Sub-module seg_slot_timer SHALL contain the slot counter and output slot_end and in_blank.

Verification (NUM_DIG=4, TICK_DIV=10, BLANK_CYC=2)
REQ-032 Reset release, no load -> dig_sel cycles 1110,1101,1011,0111, each low 8 cycles after 2 blank cycles; seg 7'h40 ("0"); frame_done every 40 cycles.
REQ-033 Load 16'h A5F1, dp 4'b0010 mid-frame -> load_ready drops next cycle; new glyphs appear only after next frame_done; digit1 shows "F" with dp=0.
REQ-034 Second load_valid while pending -> ignored; first value displayed; load_ready high the cycle after the applying wrap.
REQ-035 Load accepted on wrap slot-end cycle -> old contents shown one more frame, new contents after following wrap.
REQ-036 SEG_LZ_SUPPRESS_EN, load 16'h0007 -> digits 3..1 blanked, digit 0 shows "7"; without macro -> "0007".
REQ-037 rst pulsed low mid-SHOW with pending=1 -> outputs reset values immediately; after release contents all zero, load_ready 1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Index 15 is leftmost: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host load handshake plus display drive lines of seg_scan_ctrl.
// master = host/board side, slave = controller side.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIG = 8
);
  logic                   load_valid;
  logic                   load_ready;
  logic [4*NUM_DIG-1:0]   load_data;
  logic [NUM_DIG-1:0]     load_dp;
  logic [6:0]             seg;
  logic                   dp;
  logic [NUM_DIG-1:0]     dig_sel;
  logic                   frame_done;

  modport master (
    output load_valid, load_data, load_dp,
    input  load_ready, seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  load_valid, load_data, load_dp,
    output load_ready, seg, dp, dig_sel, frame_done
  );
endinterface

// File: rtl/seg_slot_timer.sv
// Digit slot timer: free-running 0..TICK_DIV-1 counter with slot-end and blanking flags.
// in_blank describes the count being loaded on the coming edge, so registered outputs stay in step.
module seg_slot_timer #(
  parameter int TICK_DIV  = 250000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic in_blank
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign slot_end = (cnt == CNT_W'(TICK_DIV - 1));
  assign cnt_nxt  = slot_end ? '0 : cnt + CNT_W'(1);
  assign in_blank = (cnt_nxt < CNT_W'(BLANK_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered host load.
// Optional build macro SEG_LZ_SUPPRESS_EN blanks leading-zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG   = 8,
  parameter int TICK_DIV  = 250000,
  parameter int BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_ctrl_if.slave     bus
);

  localparam int IDX_W = $clog2(NUM_DIG);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [4*NUM_DIG-1:0] active;
  logic [4*NUM_DIG-1:0] shadow;
  logic [NUM_DIG-1:0]   active_dp;
  logic [NUM_DIG-1:0]   shadow_dp;
  logic                 pending;

  logic [6:0]           seg_r;
  logic                 dp_r;
  logic [NUM_DIG-1:0]   dig_sel_r;
  logic                 frame_done_r;

  logic                 slot_end;
  logic                 in_blank;
  logic                 wrap;
  logic                 show_dig;
  logic [3:0]           nib;

  seg_slot_timer #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .in_blank (in_blank)
  );

  assign wrap = (idx == IDX_W'(NUM_DIG - 1));
  assign nib  = active[{idx, 2'b00} +: 4];

  always_comb begin
    show_dig = 1'b1;
`ifdef SEG_LZ_SUPPRESS_EN
    // Leading zero: this nibble and everything above it is zero, and no dp requested.
    if ((idx != '0) && ((active >> {idx, 2'b00}) == '0) && !active_dp[idx])
      show_dig = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BLANK;
      idx          <= '0;
      active       <= '0;
      active_dp    <= '0;
      shadow       <= '0;
      shadow_dp    <= '0;
      pending      <= 1'b0;
      seg_r        <= SEG_OFF;
      dp_r         <= 1'b1;
      dig_sel_r    <= '1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= slot_end && wrap;

      if (slot_end)
        idx <= wrap ? '0 : idx + IDX_W'(1);

      // A load accepted on the wrap edge itself has pending=0 here, so it waits a full frame.
      if (slot_end && wrap && pending) begin
        active    <= shadow;
        active_dp <= shadow_dp;
        pending   <= 1'b0;
      end else if (bus.load_valid && !pending) begin
        shadow    <= bus.load_data;
        shadow_dp <= bus.load_dp;
        pending   <= 1'b1;
      end

      case (state)
        BLANK: begin
          if (!in_blank) begin
            state <= SHOW;
            if (show_dig) begin
              seg_r     <= hex_to_seg(nib);
              dp_r      <= ~active_dp[idx];
              dig_sel_r <= ~(NUM_DIG'(1) << idx);
            end
          end
        end
        SHOW: begin
          if (in_blank) begin
            state     <= BLANK;
            seg_r     <= SEG_OFF;
            dp_r      <= 1'b1;
            dig_sel_r <= '1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  assign bus.load_ready = ~pending;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.dig_sel    = dig_sel_r;
  assign bus.frame_done = frame_done_r;

endmodule
